// File: rtl/calc_rpn_pkg.sv
// Shared definitions for the RPN calculator front-end: FSM encoding,
// data widths, switch bit positions and a small arithmetic helper.
package calc_rpn_pkg;

  localparam int DADO_W   = 8;
  localparam int OP_W     = 3;
  localparam int MODO_BIT = 9;
  localparam int NEG_BIT  = 8;

  typedef enum logic [2:0] {
    OCIOSO,
    NUMERO,
    OPERACAO,
    EXECUTA,
    ERRO,
    BLOQUEIO
  } estado_t;

  // Two's complement modulo 256; 0x00 and 0x80 map onto themselves.
  function automatic logic [7:0] complemento2(input logic [7:0] valor);
    return (~valor) + 8'd1;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// One push-button conditioner: 2-FF synchroniser, stability counter,
// debounced level and a one-cycle press pulse on a 1->0 transition.
// The press pulse is only armed once the button has been seen released
// after reset, so a key held through reset never produces a press.
module debounce_botao #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic botao,
  output logic estavel,
  output logic pressao
);

  localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [1:0]       sinc_reg;
  logic [CNT_W-1:0] cont_reg;
  logic             estavel_reg;
  logic             estavel_ant_reg;
  logic             armado_reg;
  logic             pressao_reg;

  // Synchronise, count disagreement cycles, accept the new level, detect the fall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sinc_reg        <= '0;
      cont_reg        <= '0;
      estavel_reg     <= 1'b1;
      estavel_ant_reg <= 1'b1;
      armado_reg      <= 1'b0;
      pressao_reg     <= 1'b0;
    end else begin
      sinc_reg        <= {sinc_reg[0], botao};
      estavel_ant_reg <= estavel_reg;
      pressao_reg     <= estavel_ant_reg & ~estavel_reg & armado_reg;
      if (sinc_reg[1] != estavel_reg) begin
        if (cont_reg == CNT_MAX) begin
          estavel_reg <= sinc_reg[1];
          cont_reg    <= '0;
        end else begin
          cont_reg <= cont_reg + 1'b1;
        end
      end else begin
        cont_reg <= '0;
      end
      if (estavel_reg && sinc_reg[1]) begin
        armado_reg <= 1'b1;
      end
    end
  end

  assign estavel = estavel_reg;
  assign pressao = pressao_reg;

endmodule

// File: rtl/controle_entrada_rpn.sv
// Input stage ahead of sistema_rpn: debounces KEY[1:0], latches operand /
// opcode from the switches and issues one-cycle command strobes.
// Optional build macro: ENTRADA_NEGATIVA_EN (SW[8] negates the operand).
module controle_entrada_rpn
  import calc_rpn_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int DADO_W          = calc_rpn_pkg::DADO_W,
  parameter int OP_W            = calc_rpn_pkg::OP_W
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [9:0]        SW,
  input  logic [1:0]        KEY,
  output logic [DADO_W-1:0] entrada,
  output logic [OP_W-1:0]   operacao,
  output logic              entrada_numero,
  output logic              entrada_operacao,
  output logic              executar,
  output logic              op_pendente,
  output logic              erro_seq,
  output logic              ocupado
);

  logic [1:0] estavel;
  logic [1:0] pressao;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_botao
      debounce_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
      ) u_debounce (
        .clk    (CLOCK_50),
        .reset_n(reset_n),
        .botao  (KEY[gi]),
        .estavel(estavel[gi]),
        .pressao(pressao[gi])
      );
    end
  endgenerate

  logic [7:0] operando;
`ifdef ENTRADA_NEGATIVA_EN
  assign operando = SW[NEG_BIT] ? complemento2(SW[7:0]) : SW[7:0];
`else
  logic neg_unused;
  assign neg_unused = SW[NEG_BIT];
  assign operando   = SW[7:0];
`endif

  estado_t           estado_reg, estado_next;
  logic [DADO_W-1:0] entrada_reg, entrada_next;
  logic [OP_W-1:0]   operacao_reg, operacao_next;
  logic              op_pendente_reg, op_pendente_next;
  logic              entrada_numero_reg;
  logic              entrada_operacao_reg;
  logic              executar_reg;
  logic              erro_seq_reg;
  logic              ocupado_reg;

  // Next-state and latch decisions; press0 has priority over press1.
  always_comb begin
    estado_next      = estado_reg;
    entrada_next     = entrada_reg;
    operacao_next    = operacao_reg;
    op_pendente_next = op_pendente_reg;
    case (estado_reg)
      OCIOSO: begin
        if (pressao[0]) begin
          if (SW[MODO_BIT]) begin
            operacao_next    = OP_W'(SW[2:0]);
            op_pendente_next = 1'b1;
            estado_next      = OPERACAO;
          end else begin
            entrada_next = DADO_W'(operando);
            estado_next  = NUMERO;
          end
        end else if (pressao[1]) begin
          estado_next = op_pendente_reg ? EXECUTA : ERRO;
        end
      end
      NUMERO, OPERACAO, ERRO: estado_next = BLOQUEIO;
      EXECUTA: begin
        op_pendente_next = 1'b0;
        estado_next      = BLOQUEIO;
      end
      BLOQUEIO: begin
        if (&estavel) begin
          estado_next = OCIOSO;
        end
      end
      default: estado_next = OCIOSO;
    endcase
  end

  // State, latches and strobes registered together so strobes track the state exactly.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      estado_reg           <= OCIOSO;
      entrada_reg          <= '0;
      operacao_reg         <= '0;
      op_pendente_reg      <= 1'b0;
      entrada_numero_reg   <= 1'b0;
      entrada_operacao_reg <= 1'b0;
      executar_reg         <= 1'b0;
      erro_seq_reg         <= 1'b0;
      ocupado_reg          <= 1'b0;
    end else begin
      estado_reg           <= estado_next;
      entrada_reg          <= entrada_next;
      operacao_reg         <= operacao_next;
      op_pendente_reg      <= op_pendente_next;
      entrada_numero_reg   <= (estado_next == NUMERO);
      entrada_operacao_reg <= (estado_next == OPERACAO);
      executar_reg         <= (estado_next == EXECUTA);
      erro_seq_reg         <= (estado_next == ERRO);
      ocupado_reg          <= (estado_next != OCIOSO);
    end
  end

  assign entrada          = entrada_reg;
  assign operacao         = operacao_reg;
  assign op_pendente      = op_pendente_reg;
  assign entrada_numero   = entrada_numero_reg;
  assign entrada_operacao = entrada_operacao_reg;
  assign executar         = executar_reg;
  assign erro_seq         = erro_seq_reg;
  assign ocupado          = ocupado_reg;

endmodule

// File: doc/controle_entrada_rpn.md
Name: controle_entrada_rpn

Overview:
Front-end input stage directly upstream of sistema_rpn. It synchronises and debounces the two active-low push buttons and turns switch settings into registered operand/opcode values. It then issues single-cycle strobes (entrada_numero, entrada_operacao, executar) that drive sistema_rpn's command inputs. It is instantiated inside calculadora_rpn between the board pins and sistema_rpn.

Parameters:
DEBOUNCE_CICLOS, 50000, consecutive stable cycles required to accept a key change (1 ms at 50 MHz); minimum 2
DADO_W, 8, operand width
OP_W, 3, opcode width

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
SW  input  10  SW[7:0] operand; SW[2:0] opcode; SW[8] negate (optional feature); SW[9] mode: 0=number, 1=operation
KEY  input  2  raw active-low buttons: KEY[0]=enter, KEY[1]=execute
entrada  output  DADO_W  latched operand to sistema_rpn
operacao  output  OP_W  latched opcode to sistema_rpn
entrada_numero  output  1  one-cycle strobe: push entrada
entrada_operacao  output  1  one-cycle strobe: operacao valid
executar  output  1  one-cycle strobe: execute pending operation
op_pendente  output  1  an opcode is latched and not yet executed
erro_seq  output  1  one-cycle strobe: KEY[1] pressed with no pending opcode
ocupado  output  1  FSM not in OCIOSO

Behaviour:
- Reset (reset_n=0 at a clock edge) clears every output and internal register. Debounced key state resets to released (1). FSM resets to OCIOSO. Reset mid-debounce or mid-strobe aborts it, and no strobe follows reset release.
- Sync: each KEY bit passes through a 2-FF synchroniser.
- Debounce, per key:
  - Counter increments while the synchronised value differs from the stable value; it clears when they match.
  - When the count reaches DEBOUNCE_CICLOS-1 and the values still differ, the stable value updates on the next edge.
  - Press event = stable 1->0, asserted for one cycle.
- FSM states:
  - OCIOSO:
    - press0 with SW[9]=0 -> latch SW[7:0] into entrada, go to NUMERO.
    - press0 with SW[9]=1 -> latch SW[2:0] into operacao, set op_pendente, go to OPERACAO.
    - press1 with op_pendente=1 -> go to EXECUTA.
    - press1 with op_pendente=0 -> go to ERRO.
    - If press0 and press1 occur in the same cycle, press0 wins and press1 is discarded.
  - NUMERO: entrada_numero=1 for this one cycle, then go to BLOQUEIO.
  - OPERACAO: entrada_operacao=1 for one cycle, then go to BLOQUEIO.
  - EXECUTA: executar=1 for one cycle; clear op_pendente; go to BLOQUEIO.
  - ERRO: erro_seq=1 for one cycle, then go to BLOQUEIO.
  - BLOQUEIO: wait until both debounced keys are released, then go to OCIOSO. Presses arriving in this state are ignored (no queuing).
- Strobes are registered FSM-state decodes, never asserted simultaneously. entrada and operacao hold their values until the next latch.
- Latency from a raw KEY falling edge (clean) to strobe high: 2 sync + DEBOUNCE_CICLOS + 2 (event + state) cycles, exact.
- A second opcode entry before executar overwrites operacao, and op_pendente stays 1.

Optional Feature:
ENTRADA_NEGATIVA_EN
- Defined: in a number entry with SW[8]=1, entrada latches the two's complement of SW[7:0] (mod 256, so 0x00->0x00 and 0x80->0x80).
- Undefined: SW[8] is ignored and entrada=SW[7:0].

Decomposition:
- Package calc_rpn_pkg holds:
  - FSM state encoding (OCIOSO, NUMERO, OPERACAO, EXECUTA, ERRO, BLOQUEIO)
  - DADO_W=8 and OP_W=3
  - SW bit indices (MODO_BIT=9, NEG_BIT=8)
- Sub-module debounce_botao (synchroniser + counter + stable register + press pulse) is instantiated twice, once per key.

Test Plan:
All scenarios use DEBOUNCE_CICLOS=4.
- Reset: reset_n=0 for 3 cycles with KEY=2'b00 -> all outputs 0; after release, keys held low produce no strobe until released and pressed again.
- Number push: SW=10'h02A, KEY[0] low for 20 cycles -> entrada_numero high exactly once, 8 cycles after the fall, with entrada=8'h2A; ocupado stays 1 until KEY[0] is released plus debounce.
- Bounce: KEY[0] toggles every 2 cycles for 12 cycles, then stays low -> exactly one entrada_numero pulse; none during the bounce.
- Op then execute: SW=10'h203, press/release KEY[0] -> entrada_operacao pulse, operacao=3'd3, op_pendente=1. Press KEY[1] -> one executar pulse, op_pendente=0.
- Execute without op after reset: press KEY[1] -> erro_seq pulse, executar stays 0. Simultaneous KEY=2'b00 with SW[9]=0 -> only entrada_numero.
- ENTRADA_NEGATIVA_EN defined: SW=10'h105, press KEY[0] -> entrada=8'hFB. Undefined -> 8'h05.
